// File: rtl/regbank4_32.sv
// Four-entry register bank with a single-register write port and a
// bulk-load sequencer that fills q1..q4 in order from a valid/ready stream.
module regbank4_32 #(
  parameter int unsigned      WIDTH   = 32,
  parameter logic [WIDTH-1:0] CLR_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [1:0]       wr_reg,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             ld_start,
  input  logic             ld_valid,
  input  logic [WIDTH-1:0] ld_data,
  output logic             ld_ready,
  output logic             ld_done,
  output logic             busy,
  output logic [WIDTH-1:0] q1,
  output logic [WIDTH-1:0] q2,
  output logic [WIDTH-1:0] q3,
  output logic [WIDTH-1:0] q4
);

  localparam int unsigned CNT_W = 2;
  localparam int unsigned NREG  = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [NREG-1:0]    wsel_c;
  logic [WIDTH-1:0]   wdata_c;

  // Next-state and counter logic
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      ST_IDLE: begin
        if (ld_start) begin
          state_nxt = ST_LOAD;
          cnt_nxt   = '0;
        end
      end
      ST_LOAD: begin
        if (ld_valid) begin
          cnt_nxt = cnt + CNT_W'(1);
          if (cnt == CNT_W'(NREG - 1)) begin
            state_nxt = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Write select: single-write port in IDLE, sequencer in LOAD; never both
  always_comb begin
    wsel_c  = '0;
    wdata_c = wr_data;
    if (state == ST_IDLE && wr_en) begin
      wsel_c  = NREG'(1) << wr_reg;
      wdata_c = wr_data;
    end else if (state == ST_LOAD && ld_valid) begin
      wsel_c  = NREG'(1) << cnt;
      wdata_c = ld_data;
    end
  end

  // State register; status outputs are registered from the next state so
  // they are pure decodes of the current state without a combinational path
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      busy     <= 1'b0;
      ld_ready <= 1'b0;
      ld_done  <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      busy     <= (state_nxt != ST_IDLE);
      ld_ready <= (state_nxt == ST_LOAD);
      ld_done  <= (state_nxt == ST_DONE);
    end
  end

  // Register storage
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q1 <= CLR_VAL;
      q2 <= CLR_VAL;
      q3 <= CLR_VAL;
      q4 <= CLR_VAL;
    end else begin
      if (wsel_c[0]) q1 <= wdata_c;
      if (wsel_c[1]) q2 <= wdata_c;
      if (wsel_c[2]) q3 <= wdata_c;
      if (wsel_c[3]) q4 <= wdata_c;
    end
  end

endmodule

// File: doc/regbank4_32.md
Name: regbank4_32

Overview:
- Bank of four 32-bit registers; its outputs q1..q4 drive the 4:1 register-read mux (mux4_1) directly.
- Writes come from two sources:
  - a single-register write port, addressed by a 2-bit register number and decoded with the same one-hot mapping as decoder2_4;
  - a bulk-load sequencer that fills all four registers in order from a valid/ready stream.
- The block owns all register state; the read path stays purely combinational downstream.

Parameters:
- WIDTH, 32, data width of every register and data port.
- CLR_VAL, 0, value loaded into every register on reset.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- wr_en  input  1  single-register write strobe.
- wr_reg  input  2  target register number for single write (0 selects q1 … 3 selects q4).
- wr_data  input  WIDTH  single-write data.
- ld_start  input  1  request a bulk load of all four registers.
- ld_valid  input  1  ld_data is valid this cycle.
- ld_data  input  WIDTH  bulk-load data word.
- ld_ready  output  1  bank accepts ld_data this cycle.
- ld_done  output  1  one-cycle pulse after the fourth load word is written.
- busy  output  1  sequencer not IDLE.
- q1, q2, q3, q4  output  WIDTH  register contents.

Behaviour:
- Reset:
  - Asynchronous, active-low; applies immediately on reset=0, with no wait for clk.
  - q1..q4 = CLR_VAL; state = IDLE; load counter = 0; ld_ready = 0; ld_done = 0; busy = 0.
  - Asserting reset mid-load aborts the load. Registers already written are also cleared. No ld_done is issued.
- Register update: registers change only on the rising clk edge. Values written at edge N are visible on q1..q4 immediately after edge N. There is no bypass and no read latency beyond that.
- Single write:
  - In IDLE, wr_en=1 writes wr_data into the register selected by wr_reg at the next edge.
  - Only the selected register changes; the other three hold.
  - wr_en outside IDLE is ignored and dropped, with no queuing.
- FSM states: IDLE, LOAD, DONE. Encoding is free.
- IDLE:
  - ld_start=1 → LOAD at next edge, counter := 0.
  - If wr_en=1 in the same cycle as ld_start, the single write is performed at that same edge; then LOAD begins.
- LOAD:
  - ld_ready = 1 (combinational from state).
  - On each edge with ld_valid=1, ld_data is written to register[counter] (order q1, q2, q3, q4) and counter increments.
  - ld_valid=0 stalls the sequencer with no timeout.
  - When the word with counter=3 is accepted → DONE; counter wraps to 0.
  - ld_start is ignored while in LOAD.
- DONE:
  - Lasts exactly one cycle. ld_done = 1, ld_ready = 0, busy = 1; then → IDLE unconditionally.
  - ld_start or ld_valid during DONE is ignored.
  - A new load needs ld_start in IDLE, i.e. at least one IDLE cycle between loads.
- Output decoding: busy = (state != IDLE); ld_done and ld_ready are decoded from state only.
- Width rules: counter is 2 bits. Data is written unmodified; no arithmetic is applied to data.

Test Plan:
- Reset mid-load:
  - Stimulus: reset=0 pulse mid-cycle, asynchronous to clk, during LOAD with counter=2.
  - Response: q1..q4 = 0 immediately; busy = 0; no ld_done after release.
- Single writes:
  - Stimulus: wr_reg=0..3 with data 0xA0000000+n, one per cycle.
  - Response: q1=0xA0000000, q2=..01, q3=..02, q4=..03; each register changes only on its own write edge.
- Bulk load, no stalls:
  - Stimulus: ld_start, then four consecutive ld_valid words 0x11111111, 0x22222222, 0x33333333, 0x44444444.
  - Response: q1..q4 hold those values in that order; ld_done high exactly one cycle, on the edge after the 4th accept; busy high for 5 cycles total.
- Bulk load with stalls:
  - Stimulus: ld_valid toggled 1,0,0,1,1,0,1.
  - Response: only cycles with ld_valid=1 advance the counter; final contents are correct; ld_ready stays 1 throughout LOAD.
- Write blocked during load:
  - Stimulus: wr_en=1, wr_reg=2, data 0xDEADBEEF while busy=1.
  - Response: q3 gets only its bulk-load value; the write is dropped.
- Same-cycle write and start:
  - Stimulus: wr_en(reg1, 0x5) together with ld_start in IDLE.
  - Response: q2=0x5 after that edge, then overwritten by the 2nd load word; ld_start during DONE produces no new load.
